sync_fifo_rd: RTL and testbench
===============================

SYNC_FIFO_RD -- requirements
Module: sync_fifo_rd

Interface
REQ-001 Parameter WIDTH, default 64, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, >=2.
REQ-003 Parameter AFULL_TH, default DEPTH-2, count at or above which afull asserts (1..DEPTH).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 Port wr_en  input  1  push request for din this cycle.
REQ-007 Port din  input  WIDTH  write data.
REQ-008 Port rd_en  input  1  pop request this cycle.
REQ-009 Port dout  output  WIDTH  registered read data; holds between pops; downstream may capture it with an enable flop qualified by dout_vld.
REQ-010 Port dout_vld  output  1  one-cycle pulse: dout was updated by the previous cycle's accepted pop.
REQ-011 Port full  output  1  count == DEPTH.
REQ-012 Port afull  output  1  count >= AFULL_TH.
REQ-013 Port empty  output  1  count == 0.
REQ-014 Port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 Port ovf  output  1  sticky: a push was dropped because full.
REQ-016 Port udf  output  1  sticky: a pop was dropped because empty.
REQ-017 Port clr_err  input  1  synchronous clear of ovf and udf.

Function
REQ-018 Push accepted iff wr_en && !full (full sampled at the start of the cycle); din written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Pop accepted iff rd_en && !empty; entry at rd_ptr loaded into dout at that edge, rd_ptr increments modulo DEPTH, dout_vld=1 the following cycle.
REQ-020 Read latency: dout/dout_vld valid exactly one cycle after the accepted rd_en cycle; no combinational path rd_en->dout.
REQ-021 dout retains its last value when no pop is accepted; dout_vld=0 in such cycles.
REQ-022 No fall-through: a push into an empty FIFO is not poppable until the next cycle; rd_en in that cycle is a dropped pop.
REQ-023 Push and pop both accepted in one cycle: count unchanged, both pointers advance.
REQ-024 When full, push is dropped even if a pop is accepted that same cycle; storage unaffected.
REQ-025 count: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-026 full, afull, empty are registered-state decodes of count, updated the cycle after the causing edge.
REQ-027 Dropped push sets ovf; dropped pop sets udf; both stay set until clr_err.
REQ-028 clr_err clears ovf/udf next edge; a new error in the same cycle as clr_err wins (flag stays 1).
REQ-029 Pointer wrap: after DEPTH accepted pushes wr_ptr returns to 0; data order preserved across wrap.
REQ-030 Storage contents are not reset; only pointers, count, flags, dout and dout_vld are.

Reset
REQ-031 While rst=1 (asynchronously on assertion): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, afull=0 (AFULL_TH>=1), dout=0, dout_vld=0, ovf=0, udf=0.
REQ-032 rst asserted mid-operation discards all queued entries; no pop completes in the reset cycle.
REQ-033 First push accepted on the first rising edge with rst=0.

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3)
REQ-034 Push 0x11,0x22,0x33 then pop 3 -> dout 0x11,0x22,0x33 on consecutive cycles each with dout_vld=1; count 3->0; afull=1 only at count 3; empty=1 at end.
REQ-035 Push 5 words 0xA0..0xA4 with no pops -> full=1 after 4th, 0xA4 dropped, ovf=1, count=4; pop 4 -> 0xA0..0xA3.
REQ-036 Pop with empty=1 -> dout unchanged, dout_vld=0, udf=1, count=0; clr_err=1 one cycle -> udf=0.
REQ-037 Fill to 3, then 10 cycles simultaneous push (0xB0..0xB9) and pop -> count stays 3, pointers wrap, outputs strictly in push order.
REQ-038 Full, simultaneous wr_en=1 and rd_en=1 -> pop accepted, push dropped, ovf=1, count=3.
REQ-039 Fill to 2, assert rst asynchronously mid-cycle -> outputs immediately at REQ-031 values; after release, push 0x5A, pop -> dout=0x5A.

Source files
------------

// File: rtl/sync_fifo_rd_if.sv
// sync_fifo_rd_if -- handshake/data bundle for the registered-read synchronous FIFO.
//   master : producer/consumer side (drives wr_en, din, rd_en, clr_err; observes the rest)
//   slave  : FIFO side (the reverse)
//   Signals: wr_en/din push request, rd_en pop request, dout/dout_vld registered read data and
//            its one-cycle valid pulse, full/afull/empty/count occupancy status, ovf/udf sticky
//            drop flags, clr_err synchronous flag clear.
interface sync_fifo_rd_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             wr_en;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic             full;
   logic             afull;
   logic             empty;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             udf;
   logic             clr_err;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  dout, dout_vld, full, afull, empty, count, ovf, udf
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output dout, dout_vld, full, afull, empty, count, ovf, udf
   );
endinterface

// File: rtl/sync_fifo_rd.sv
// sync_fifo_rd -- single-clock FIFO with a registered read port (no fall-through).
//   clk : rising-edge clock for all state
//   rst : asynchronous, active-high reset of pointers, count, flags, dout and dout_vld
//   bus : sync_fifo_rd_if.slave carrying push/pop requests, read data and status
// A pop accepted at an edge loads dout at that same edge, so dout/dout_vld appear one cycle
// after the rd_en cycle. Status outputs are registered decodes of the next count. Storage
// is not reset.
module sync_fifo_rd #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned DEPTH    = 8,
   // Must lie in 1..DEPTH; the default is only meaningful for DEPTH >= 3.
   parameter int unsigned AFULL_TH = DEPTH - 2
) (
   input  logic          clk,
   input  logic          rst,
   sync_fifo_rd_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             empty_q, empty_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic push, pop;

   // Acceptance uses the registered flags, so a pop in the same cycle never frees room for a
   // push into a full FIFO, and a push into an empty FIFO is never readable the same cycle.
   assign push = bus.wr_en && !full_q;
   assign pop  = bus.rd_en && !empty_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      dout_d     = dout_q;
      dout_vld_d = pop;

      // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem[rd_ptr_q];
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      afull_d = (count_d >= CW'(AFULL_TH));
      empty_d = (count_d == '0);

      // A drop in the same cycle as clr_err keeps the flag set.
      ovf_d = (ovf_q && !bus.clr_err) || (bus.wr_en && full_q);
      udf_d = (udf_q && !bus.clr_err) || (bus.rd_en && empty_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         empty_q    <= 1'b1;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         empty_q    <= empty_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   // Storage has no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.din;
   end

   assign bus.dout     = dout_q;
   assign bus.dout_vld = dout_vld_q;
   assign bus.full     = full_q;
   assign bus.afull    = afull_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.ovf      = ovf_q;
   assign bus.udf      = udf_q;
endmodule

// File: tb/tb_sync_fifo_rd.sv
// tb_sync_fifo_rd -- directed-vector bench for sync_fifo_rd at WIDTH=8, DEPTH=4, AFULL_TH=3.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_sync_fifo_rd;
   logic clk;
   logic rst;

   int unsigned vec_cnt;
   int unsigned err_cnt;

   sync_fifo_rd_if #(.WIDTH(8), .DEPTH(4)) bus_if ();

   sync_fifo_rd #(
      .WIDTH    (8),
      .DEPTH    (4),
      .AFULL_TH (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
      bus_if.wr_en   = wr;
      bus_if.din     = d;
      bus_if.rd_en   = rd;
      bus_if.clr_err = clr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst     = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check_val("rst_count", bus_if.count, 0);
      check_val("rst_empty", bus_if.empty, 1);
      check_val("rst_full", bus_if.full, 0);
      check_val("rst_afull", bus_if.afull, 0);
      check_val("rst_dout", bus_if.dout, 0);
      check_val("rst_vld", bus_if.dout_vld, 0);
      check_val("rst_ovf", bus_if.ovf, 0);
      check_val("rst_udf", bus_if.udf, 0);
      rst = 1'b0;

      // Basic push 3 / pop 3; afull only at count 3
      drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
      check_val("b_cnt1", bus_if.count, 1);
      check_val("b_empty1", bus_if.empty, 0);
      check_val("b_af1", bus_if.afull, 0);
      drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
      check_val("b_af2", bus_if.afull, 0);
      drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
      check_val("b_cnt3", bus_if.count, 3);
      check_val("b_af3", bus_if.afull, 1);
      check_val("b_vld_push", bus_if.dout_vld, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      check_val("b_dout0", bus_if.dout, 8'h11);
      check_val("b_vld0", bus_if.dout_vld, 1);
      check_val("b_cntp0", bus_if.count, 2);
      check_val("b_afp0", bus_if.afull, 0);
      tick();
      check_val("b_dout1", bus_if.dout, 8'h22);
      check_val("b_vld1", bus_if.dout_vld, 1);
      tick();
      check_val("b_dout2", bus_if.dout, 8'h33);
      check_val("b_vld2", bus_if.dout_vld, 1);
      check_val("b_cnt_end", bus_if.count, 0);
      check_val("b_empty_end", bus_if.empty, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
      check_val("b_hold_dout", bus_if.dout, 8'h33);
      check_val("b_hold_vld", bus_if.dout_vld, 0);
      check_val("b_udf_none", bus_if.udf, 0);

      // Overflow: push A0..A4, A4 dropped
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0); tick();
         if (i == 3) begin
            check_val("o_full4", bus_if.full, 1);
            check_val("o_ovf_pre", bus_if.ovf, 0);
         end
      end
      check_val("o_ovf", bus_if.ovf, 1);
      check_val("o_cnt", bus_if.count, 4);
      check_val("o_full", bus_if.full, 1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("o_dout", bus_if.dout, 8'hA0 + 8'(i));
         check_val("o_vld", bus_if.dout_vld, 1);
      end
      check_val("o_empty", bus_if.empty, 1);
      check_val("o_full_clr", bus_if.full, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      check_val("o_ovf_clr", bus_if.ovf, 0);

      // Underflow on empty, then clear
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      check_val("u_dout", bus_if.dout, 8'hA3);
      check_val("u_vld", bus_if.dout_vld, 0);
      check_val("u_udf", bus_if.udf, 1);
      check_val("u_cnt", bus_if.count, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
      check_val("u_sticky", bus_if.udf, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      check_val("u_clr", bus_if.udf, 0);

      // No fall-through: push+pop into empty drops the pop
      drive(1'b1, 8'h77, 1'b1, 1'b0); tick();
      check_val("nf_vld", bus_if.dout_vld, 0);
      check_val("nf_udf", bus_if.udf, 1);
      check_val("nf_cnt", bus_if.count, 1);
      // Error in the same cycle as clr_err wins: pop succeeds here so udf clears instead
      drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
      check_val("nf_dout", bus_if.dout, 8'h77);
      check_val("nf_vld2", bus_if.dout_vld, 1);
      check_val("nf_udf_clr", bus_if.udf, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
      check_val("err_wins", bus_if.udf, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      check_val("err_clr2", bus_if.udf, 0);

      // Fill to 3, then 10 cycles of simultaneous push/pop across pointer wrap
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0); tick();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0); tick();
         check_val("s_dout", bus_if.dout, (i < 3) ? 8'hC0 + 8'(i) : 8'hB0 + 8'(i - 3));
         check_val("s_vld", bus_if.dout_vld, 1);
         check_val("s_cnt", bus_if.count, 3);
      end
      check_val("s_ovf", bus_if.ovf, 0);
      check_val("s_udf", bus_if.udf, 0);

      // Full with simultaneous push/pop: pop accepted, push dropped
      drive(1'b1, 8'hBA, 1'b0, 1'b0); tick();
      check_val("f_full", bus_if.full, 1);
      drive(1'b1, 8'hEE, 1'b1, 1'b0); tick();
      check_val("f_dout", bus_if.dout, 8'hB7);
      check_val("f_cnt", bus_if.count, 3);
      check_val("f_ovf", bus_if.ovf, 1);
      check_val("f_full_off", bus_if.full, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("f_drain", bus_if.dout, 8'hB8 + 8'(i));
      end
      check_val("f_empty", bus_if.empty, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();

      // Async reset mid-cycle with 2 queued entries
      drive(1'b1, 8'hD0, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hD1, 1'b1, 1'b0); tick();
      drive(1'b1, 8'hD2, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check_val("r_pre_cnt", bus_if.count, 1);
      check_val("r_pre_dout", bus_if.dout, 8'hD1);
      drive(1'b1, 8'hD3, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("r_pre_cnt2", bus_if.count, 2);
      #2 rst = 1'b1;
      #1;
      check_val("r_cnt", bus_if.count, 0);
      check_val("r_empty", bus_if.empty, 1);
      check_val("r_dout", bus_if.dout, 0);
      check_val("r_vld", bus_if.dout_vld, 0);
      @(posedge clk);
      #1;
      check_val("r_no_pop", bus_if.dout_vld, 0);
      rst = 1'b0;
      drive(1'b1, 8'h5A, 1'b0, 1'b0); tick();
      check_val("r_cnt1", bus_if.count, 1);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      check_val("r_dout5a", bus_if.dout, 8'h5A);
      check_val("r_vld5a", bus_if.dout_vld, 1);
      tick();
      check_val("r_discard_vld", bus_if.dout_vld, 0);
      check_val("r_discard_udf", bus_if.udf, 1);
      check_val("r_discard_cnt", bus_if.count, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
